// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the sequential 8x8 multiplier controller:
//   - controller state encoding
//   - step count and step-counter width
//   - per-step alignment shift of the 4x4 partial product
//   - per-step nibble selects for the a and b operands
//   - helper that aligns a partial product to its weight in the 16-bit sum
// -----------------------------------------------------------------------------
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_STEPS = 4;
   localparam int STEP_W    = 2;

   localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

   // Partial product weights: aL*bL, aH*bL, aL*bH, aH*bH.
   localparam logic [3:0] STEP_SHIFT [NUM_STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

   // Bit n set means step n uses the high nibble of that operand.
   localparam logic [NUM_STEPS-1:0] STEP_A_HI = 4'b1010;
   localparam logic [NUM_STEPS-1:0] STEP_B_HI = 4'b1100;

   // Place an 8-bit partial product at its weight inside the 16-bit sum.
   function automatic logic [15:0] align_pp(input logic [7:0]        pp,
                                            input logic [STEP_W-1:0] step);
      align_pp = {8'h00, pp} << STEP_SHIFT[step];
   endfunction

endpackage

// File: rtl/array_multiplier_4bit.sv
// -----------------------------------------------------------------------------
// array_multiplier_4bit
// Combinational unsigned 4x4 -> 8-bit array multiplier: the shared datapath
// that the sequencing controller reuses once per step.
// Ports:
//   a  input  4  multiplicand nibble
//   b  input  4  multiplier nibble
//   p  output 8  product a*b (combinational)
// -----------------------------------------------------------------------------
module array_multiplier_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [7:0] sum_s;

   // Sum of the four AND-gated rows, each row shifted by its multiplier bit.
   always_comb begin
      sum_s = 8'h00;
      for (int i = 0; i < 4; i++) begin
         sum_s = sum_s + ({4'h0, a & {4{b[i]}}} << i);
      end
   end

   assign p = sum_s;

endmodule

// File: rtl/mul8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul8_seq_ctrl
// Unsigned 8x8 -> 16-bit multiplier that runs the product through one shared
// 4x4 array multiplier over four cycles, with valid/ready on both sides.
// Accept -> four MUL cycles -> DONE (result held until the consumer takes it).
// With FAST_ZERO=1 a zero operand skips the MUL cycles and lands in DONE with
// a zero product straight away.
// Ports:
//   clk        input   1   clock, rising edge
//   rst        input   1   synchronous active-high reset
//   in_valid   input   1   operand pair valid
//   in_ready   output  1   controller idle and able to take operands
//   a          input   8   multiplicand
//   b          input   8   multiplier
//   out_valid  output  1   product valid (held until accepted)
//   out_ready  input   1   consumer takes the product
//   p          output  16  registered product
//   busy       output  1   controller not idle
// -----------------------------------------------------------------------------
module mul8_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter bit FAST_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] p,
   output logic        busy
);

   state_t              state_r;
   logic [STEP_W-1:0]   step_r;
   logic [7:0]          a_r;
   logic [7:0]          b_r;
   logic [15:0]         acc_r;
   logic [15:0]         p_r;

   logic [3:0]          mul_a_s;
   logic [3:0]          mul_b_s;
   logic [7:0]          pp_s;
   logic [15:0]         sum_s;

   // Nibble select for the shared multiplier; only the latched operands feed
   // it, so the a/b ports may change freely once an operation is accepted.
   always_comb begin
      mul_a_s = 4'h0;
      mul_b_s = 4'h0;
      if (STEP_A_HI[step_r]) begin
         mul_a_s = a_r[7:4];
      end else begin
         mul_a_s = a_r[3:0];
      end
      if (STEP_B_HI[step_r]) begin
         mul_b_s = b_r[7:4];
      end else begin
         mul_b_s = b_r[3:0];
      end
   end

   array_multiplier_4bit u_mul4 (
      .a (mul_a_s),
      .b (mul_b_s),
      .p (pp_s)
   );

   // Running sum; 255*255 fits in 16 bits so no carry-out is possible.
   assign sum_s = acc_r + align_pp(pp_s, step_r);

   // Controller FSM with operand latches, step counter, accumulator and product.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         step_r  <= 2'd0;
         a_r     <= 8'h00;
         b_r     <= 8'h00;
         acc_r   <= 16'h0000;
         p_r     <= 16'h0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r    <= a;
                  b_r    <= b;
                  acc_r  <= 16'h0000;
                  step_r <= 2'd0;
                  if (FAST_ZERO && ((a == 8'h00) || (b == 8'h00))) begin
                     p_r     <= 16'h0000;
                     state_r <= DONE;
                  end else begin
                     state_r <= MUL;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            MUL: begin
               acc_r <= sum_s;
               if (step_r == LAST_STEP) begin
                  p_r     <= sum_s;
                  step_r  <= 2'd0;
                  state_r <= DONE;
               end else begin
                  step_r  <= step_r + 2'd1;
                  state_r <= MUL;
               end
            end
            DONE: begin
               // No operand is taken here even with out_ready high; the next
               // accept happens in the following IDLE cycle.
               if (out_ready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r <= IDLE;
               step_r  <= 2'd0;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign busy      = (state_r != IDLE);
   assign out_valid = (state_r == DONE);
   assign p         = p_r;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul8_seq_ctrl
// Self-checking bench for mul8_seq_ctrl. Two instances: dut (FAST_ZERO=1) and
// dut0 (FAST_ZERO=0). Expected products are pushed to a queue when operands
// are presented and popped when the product appears.
// -----------------------------------------------------------------------------
module tb_mul8_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0]  a, b;
   logic [15:0] p;
   logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
   logic [7:0]  a0, b0;
   logic [15:0] p0;

   int          vectors;
   int          miscompares;
   logic [15:0] exp_q[$];

   mul8_seq_ctrl #(.FAST_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
   );

   mul8_seq_ctrl #(.FAST_ZERO(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
      .out_valid(out_valid0), .out_ready(out_ready0), .p(p0), .busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand pair to dut for a single accept edge.
   task automatic issue(input logic [7:0] ta, input logic [7:0] tb);
      in_valid = 1'b1;
      a = ta;
      b = tb;
      exp_q.push_back(16'(ta) * 16'(tb));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for dut out_valid; lat=1 means visible right after accept.
   task automatic wait_out(output int lat, output bit saw_ready);
      lat = 1;
      saw_ready = 1'b0;
      while (!out_valid && lat < 20) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Common checks for one full operation on dut with out_ready high.
   task automatic check_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                           input int want_lat);
      int lat;
      bit saw_ready;
      logic [15:0] exp;
      out_ready = 1'b1;
      issue(ta, tb);
      wait_out(lat, saw_ready);
      vectors++;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_timeout: out_valid=%b after %0d cycles, want 1", name, out_valid, lat);
      end
      vectors++;
      if (lat !== want_lat) begin
         miscompares++;
         $display("FAIL %s_latency: got %0d cycles want %0d", name, lat, want_lat);
      end
      exp = exp_q.pop_front();
      vectors++;
      if (p !== exp) begin
         miscompares++;
         $display("FAIL %s_product: got %h want %h", name, p, exp);
      end
      vectors++;
      if (saw_ready !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_busy: saw_ready=%b in_ready=%b busy=%b want 0 0 1",
                  name, saw_ready, in_ready, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_release: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || p !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_fz1: in_ready=%b busy=%b out_valid=%b p=%h want 1 0 0 0000",
                  in_ready, busy, out_valid, p);
      end
      vectors++;
      if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0 || p0 !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_fz0: in_ready=%b busy=%b out_valid=%b p=%h want 1 0 0 0000",
                  in_ready0, busy0, out_valid0, p0);
      end
   endtask

   task automatic test_basic();
      check_op("basic_12x34", 8'h12, 8'h34, 5);
   endtask

   task automatic test_shift_paths();
      check_op("max_ffxff", 8'hFF, 8'hFF, 5);
      check_op("shift_80x02", 8'h80, 8'h02, 5);
      check_op("shift_02x80", 8'h02, 8'h80, 5);
   endtask

   task automatic test_fast_zero();
      int lat;
      logic [15:0] exp;
      check_op("fz_00xab", 8'h00, 8'hAB, 1);
      check_op("fz_5ax00", 8'h5A, 8'h00, 1);
      // Same zero operand on the instance without the bypass.
      in_valid0 = 1'b1;
      a0 = 8'h00;
      b0 = 8'hAB;
      exp_q.push_back(16'(a0) * 16'(b0));
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      lat = 1;
      while (!out_valid0 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (lat !== 5) begin
         miscompares++;
         $display("FAIL nofz_latency: got %0d cycles want 5", lat);
      end
      exp = exp_q.pop_front();
      vectors++;
      if (out_valid0 !== 1'b1 || p0 !== exp) begin
         miscompares++;
         $display("FAIL nofz_product: out_valid=%b p=%h want 1 %h", out_valid0, p0, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int lat;
      bit saw_ready;
      logic [15:0] exp;
      out_ready = 1'b0;
      issue(8'h0F, 8'h0F);
      wait_out(lat, saw_ready);
      vectors++;
      if (out_valid !== 1'b1 || lat !== 5) begin
         miscompares++;
         $display("FAIL bp_arrival: out_valid=%b lat=%0d want 1 5", out_valid, lat);
      end
      exp = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a = 8'h11;
         b = 8'h22;
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== exp) begin
            miscompares++;
            $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b p=%h want 1 0 %h",
                     i, out_valid, in_ready, p, exp);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_no_ghost: busy=%b out_valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_corruption();
      int lat;
      bit saw_ready;
      logic [15:0] exp;
      out_ready = 1'b1;
      issue(8'h5A, 8'hC3);
      a = 8'hFF;
      b = 8'hFF;
      wait_out(lat, saw_ready);
      exp = exp_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || p !== exp || p !== 16'h448E) begin
         miscompares++;
         $display("FAIL corrupt_product: out_valid=%b p=%h want 1 448e", out_valid, p);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      a = 8'h77;
      b = 8'h99;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_inflight: busy=%b out_valid=%b want 1 0", busy, out_valid);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || p !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_state: out_valid=%b p=%h in_ready=%b busy=%b want 0 0000 1 0",
                  out_valid, p, in_ready, busy);
      end
      check_op("rstmid_03x07", 8'h03, 8'h07, 5);
   endtask

   task automatic test_back_to_back();
      logic [7:0]  va, vb;
      logic [15:0] exp;
      int acc_n, out_n, last_out, cyc;
      bit acc_now;
      acc_n = 0;
      out_n = 0;
      last_out = -1;
      cyc = 0;
      out_ready = 1'b1;
      va = 8'($urandom_range(255, 1));
      vb = 8'($urandom_range(255, 1));
      a = va;
      b = vb;
      in_valid = 1'b1;
      while (out_n < 4 && cyc < 100) begin
         acc_now = in_ready && in_valid;
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            exp_q.push_back(16'(va) * 16'(vb));
            acc_n++;
            va = 8'($urandom_range(255, 1));
            vb = 8'($urandom_range(255, 1));
            a = va;
            b = vb;
            if (acc_n == 4) in_valid = 1'b0;
         end
         if (out_valid) begin
            exp = exp_q.pop_front();
            vectors++;
            if (p !== exp) begin
               miscompares++;
               $display("FAIL b2b_product_%0d: got %h want %h", out_n, p, exp);
            end
            if (last_out >= 0) begin
               vectors++;
               if (cyc - last_out !== 6) begin
                  miscompares++;
                  $display("FAIL b2b_spacing_%0d: got %0d cycles want 6", out_n, cyc - last_out);
               end
            end
            last_out = cyc;
            out_n++;
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (out_n !== 4) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d results want 4", out_n);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      a = 8'h00;
      b = 8'h00;
      out_ready = 1'b1;
      in_valid0 = 1'b0;
      a0 = 8'h00;
      b0 = 8'h00;
      out_ready0 = 1'b1;
      test_reset();
      test_basic();
      test_shift_paths();
      test_fast_zero();
      test_backpressure();
      test_corruption();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
- Sequencing controller that computes an unsigned 8x8 -> 16-bit product using one shared 4x4 -> 8-bit array multiplier datapath over four cycles.
- Uses valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer wherever a full 8x8 multiplier array is too costly.

Parameters:
- FAST_ZERO, 1, when 1 an operand of zero at accept bypasses the step sequence and produces a zero result with 1-cycle latency; when 0 every operation runs all four steps.

Ports:
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  16  product a*b, unsigned
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; p=0, out_valid=0, step=0, accumulator=0.
  - in_ready=1 and busy=0 from the first cycle after reset.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b, clear the accumulator, set step=0, go to MUL.
  - IDLE, FAST_ZERO=1 with a==0 or b==0: go directly to DONE with p=0.
  - MUL: in_ready=0. One step per cycle, step 0..3:
    - step0: aL*bL, shift 0
    - step1: aH*bL, shift 4
    - step2: aL*bH, shift 4
    - step3: aH*bH, shift 8
  - MUL accumulate: acc <= acc + (pp8 << shift), 16-bit. The maximum is 255*255=0xFE01, so there is no overflow and no carry-out.
  - MUL exit: after step3, p <= final sum, out_valid <= 1, go to DONE.
  - DONE: out_valid=1 and p held stable. On out_ready=1, out_valid <= 0 and go to IDLE. With out_ready=0, hold indefinitely.
- Handshake rules:
  - in_ready depends only on state, never combinationally on in_valid.
  - out_valid, once high, stays high and p stays unchanged until accepted.
  - No accept occurs in DONE, even if out_ready=1 in the same cycle; a new operand is accepted in the following IDLE cycle.
- Latency and throughput:
  - Accept at edge T; MUL cycles T+1..T+4; out_valid high from T+5.
  - FAST_ZERO bypass: out_valid high from T+1.
  - Sustained throughput is 1 result per 6 cycles with out_ready tied high.
- Datapath select:
  - The 4x4 multiplier operands are a 4-bit mux selected by step, driven from the latched operands only.
  - Changes on the a/b ports after accept must not affect the result.
- Outputs: p is registered; out_valid, in_ready and busy are decoded from the state register.

Decomposition:
- Shared package mul_seq_pkg holds:
  - state enum {IDLE, MUL, DONE}
  - step-count constant NUM_STEPS=4
  - per-step shift constants {0,4,4,8}
  - per-step nibble-select constants
- One sub-module instance: array_multiplier_4bit as the shared 4x4 datapath. Its output is combinational and is consumed in the same cycle by the accumulator.
- The controller FSM, operand latches and accumulator live in mul8_seq_ctrl.

Test Plan:
- a=0x12, b=0x34, out_ready=1 -> out_valid high exactly 5 cycles after accept, p=0x03A8, in_ready low during MUL and DONE.
- a=0xFF, b=0xFF -> p=0xFE01; also a=0x80, b=0x02 -> p=0x0100, checking the step1/step2 shift-4 paths.
- FAST_ZERO=1: a=0x00, b=0xAB -> out_valid 1 cycle after accept, p=0x0000. FAST_ZERO=0 with the same operands -> p=0x0000 after 5 cycles.
- Backpressure: a=0x0F, b=0x0F, out_ready held 0 for 10 cycles -> p=0x00E1 stable, out_valid high, in_ready low, in_valid pulses ignored. Raising out_ready -> out_valid 0 and in_ready 1 next cycle.
- Operand corruption: after accepting a=0x5A, b=0xC3, drive a=0xFF, b=0xFF during MUL -> p=0x448E.
- Reset in MUL at step2 -> next cycle out_valid=0, p=0, in_ready=1. A following op a=0x03, b=0x07 -> p=0x0015, with no residue from the aborted op.
